// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions (package mdu_defs).
// Start codes, default latencies and datapath width are also used by the
// E-stage control unit and the hazard unit, so they live here.
// Optional feature macro: MDU_DIV0_HOLD_EN (see mult_div_unit.sv).
package mdu_defs;

  localparam int WIDTH       = 32;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [2:0] MD_START_NONE  = 3'd0;
  localparam logic [2:0] MD_START_MULTU = 3'd1;
  localparam logic [2:0] MD_START_MULT  = 3'd2;
  localparam logic [2:0] MD_START_DIVU  = 3'd3;
  localparam logic [2:0] MD_START_DIV   = 3'd4;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Larger of the two latencies, used to size the busy counter.
  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/data bundle between the E-stage and the multiply/divide unit.
// Handshake: there is no valid/ready pair. A non-zero start code (or the
// MD_write_enable strobe) is accepted on the rising edge only while busy is
// low and req is low; anything presented while busy is high is dropped, so
// the hazard unit must stall md-class instructions on busy.
interface mult_div_unit_if #(
  parameter int W = mdu_defs::WIDTH
);
  logic [2:0]   start;
  logic         MDaddress;
  logic         MD_write_enable;
  logic         req;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic [W-1:0] MD_rdata;

  modport master (
    output start, MDaddress, MD_write_enable, req, A, B,
    input  busy, MD_rdata
  );

  modport slave (
    input  start, MDaddress, MD_write_enable, req, A, B,
    output busy, MD_rdata
  );
endinterface

// File: rtl/mult_div_unit_busy_timer.sv
// Busy timer for the multiply/divide unit: loads LAT-1, counts down, and
// holds busy high for exactly LAT cycles. done is high during the last busy
// cycle so the owner can commit results on the same edge busy falls.
module mdu_busy_timer
  import mdu_defs::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             busy_o,
  output logic             done_o,
  output md_state_e        state_o
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // IDLE/BUSY controller with registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (load_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= lat_i - 1'b1;
            busy_q  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = (state_q == MD_BUSY) && (cnt_q == '0);
  assign state_o = state_q;

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, mthi/mtlo writes and
// fixed-latency multiply/divide with a busy flag for the hazard unit.
// The result is computed when the op is accepted and held in hi_nxt/lo_nxt;
// it only becomes architecturally visible when the timer finishes.
// Optional feature macro: MDU_DIV0_HOLD_EN -- when defined, div/divu with a
// zero divisor is not accepted at all (no busy, HI/LO unchanged). When
// undefined, it runs the full divide latency and yields HI=A, LO=all ones.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH       = mdu_defs::WIDTH,
  parameter int MULT_CYCLES = mdu_defs::MULT_CYCLES,
  parameter int DIV_CYCLES  = mdu_defs::DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   md,
  output md_state_e        dbg_state_o
);

  localparam int CNT_W = $clog2(max_lat(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_nxt_q, lo_nxt_q;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic             busy, done;
  logic             is_mul, is_div, start_ok, wr_ok;
  logic [CNT_W-1:0] lat;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag;
  logic               a_neg, b_neg, signed_op;

  // Decode the start code and decide whether this cycle's command is taken.
  always_comb begin
    is_mul = (md.start == MD_START_MULTU) || (md.start == MD_START_MULT);
    is_div = (md.start == MD_START_DIVU)  || (md.start == MD_START_DIV);
`ifdef MDU_DIV0_HOLD_EN
    if (md.B == '0) is_div = 1'b0;
`endif
    start_ok = !busy && !md.req && (is_mul || is_div);
    wr_ok    = !busy && !md.req && md.MD_write_enable && !start_ok;
    lat      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // Full-width product and sign-magnitude divide for the pending result.
  always_comb begin
    signed_op = (md.start == MD_START_MULT) || (md.start == MD_START_DIV);
    a_neg     = signed_op && md.A[WIDTH-1];
    b_neg     = signed_op && md.B[WIDTH-1];
    // Sign-extending to 2W and multiplying unsigned gives the correct
    // low 2W bits of the signed product.
    prod = {{WIDTH{a_neg}}, md.A} * {{WIDTH{b_neg}}, md.B};
    a_mag   = a_neg ? (~md.A + 1'b1) : md.A;
    b_mag   = b_neg ? (~md.B + 1'b1) : md.B;
    divisor = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    // 0x80000000 / -1 falls out naturally: its magnitude quotient negates
    // back to 0x80000000 with a zero remainder.
    q_mag = a_mag / divisor;
    r_mag = a_mag % divisor;
    hi_d  = prod[2*WIDTH-1:WIDTH];
    lo_d  = prod[WIDTH-1:0];
    if (is_div) begin
      if (md.B == '0) begin
        hi_d = md.A;
        lo_d = '1;
      end else begin
        lo_d = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        hi_d = a_neg ? (~r_mag + 1'b1) : r_mag;
      end
    end
  end

  mdu_busy_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (start_ok),
    .lat_i   (lat),
    .busy_o  (busy),
    .done_o  (done),
    .state_o (dbg_state_o)
  );

  // Pending-result capture, commit on timer completion, and mt writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_nxt_q <= '0;
      lo_nxt_q <= '0;
    end else begin
      if (start_ok) begin
        hi_nxt_q <= hi_d;
        lo_nxt_q <= lo_d;
      end
      if (done) begin
        hi_q <= hi_nxt_q;
        lo_q <= lo_nxt_q;
      end else if (wr_ok) begin
        if (md.MDaddress) hi_q <= md.A;
        else              lo_q <= md.A;
      end
    end
  end

  assign md.busy     = busy;
  assign md.MD_rdata = md.MDaddress ? hi_q : lo_q;

endmodule
